// File: rtl/axi_register_port_arbiter.sv
// Round-robin arbiter sharing the axi_slave_impl user register port among N requesters.
// Sequences read/write/complete op codes and returns read data with a one-cycle done pulse.
module axi_register_port_arbiter #(
    parameter int unsigned NUMBER_OF_REQUESTERS = 4,
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned NUMBER_OF_REGISTERS  = 6,
    parameter int unsigned READ_LATENCY         = 1
) (
    input  logic                                             S_AXI_ACLK,
    input  logic                                             S_AXI_ARESETN,
    input  logic [NUMBER_OF_REQUESTERS-1:0]                  req_valid,
    input  logic [NUMBER_OF_REQUESTERS-1:0]                  req_write,
    input  logic [8*NUMBER_OF_REQUESTERS-1:0]                req_number,
    input  logic [C_S_AXI_DATA_WIDTH*NUMBER_OF_REQUESTERS-1:0] req_wdata,
    output logic [NUMBER_OF_REQUESTERS-1:0]                  req_done,
    output logic                                             req_error,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                    req_rdata,
    output logic                                             busy,
    output logic [1:0]                                       register_operation,
    output logic [7:0]                                       register_number,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                    register_write,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                    register_read
);

    localparam int unsigned N     = NUMBER_OF_REQUESTERS;
    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned ID_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

    localparam logic [1:0] OP_IDLE     = 2'd0;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_WRITE    = 2'd2;
    localparam logic [1:0] OP_COMPLETE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_COMPLETE,
        ST_ERROR
    } state_t;

    state_t            state, state_d;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              write_q, write_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        number_d;
    logic [DW-1:0]     wdata_d;
    logic [1:0]        op_d;
    logic [N-1:0]      done_d;
    logic              error_d;
    logic [DW-1:0]     rdata_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   idx;
    logic [7:0]        grant_number;
    logic [DW-1:0]     grant_wdata;
    logic              grant_write;

    // First valid requester at or above rr_ptr, wrapping modulo N
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % N);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
        grant_number = 8'(req_number >> (32'(grant_id) * 8));
        grant_wdata  = DW'(req_wdata >> (32'(grant_id) * DW));
        grant_write  = req_write[grant_id];
    end

    // Next state and next registered outputs
    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        id_d     = id_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        number_d = register_number;
        wdata_d  = register_write;
        op_d     = OP_IDLE;
        done_d   = '0;
        error_d  = 1'b0;
        rdata_d  = '0;

        case (state)
            ST_IDLE: begin
                if (grant_found) begin
                    id_d     = grant_id;
                    write_d  = grant_write;
                    rr_ptr_d = ID_W'((32'(grant_id) + 32'd1) % N);
                    if (32'(grant_number) >= NUMBER_OF_REGISTERS) begin
                        // Rejected without touching the slave port
                        state_d          = ST_ERROR;
                        done_d[grant_id] = 1'b1;
                        error_d          = 1'b1;
                    end else begin
                        state_d  = ST_ISSUE;
                        op_d     = grant_write ? OP_WRITE : OP_READ;
                        number_d = grant_number;
                        wdata_d  = grant_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(READ_LATENCY - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_COMPLETE;
                    op_d         = OP_COMPLETE;
                    done_d[id_q] = 1'b1;
                    rdata_d      = write_q ? '0 : register_read;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            ST_ERROR:    state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state              <= ST_IDLE;
            rr_ptr             <= '0;
            id_q               <= '0;
            write_q            <= 1'b0;
            cnt_q              <= '0;
            register_operation <= OP_IDLE;
            register_number    <= '0;
            register_write     <= '0;
            req_done           <= '0;
            req_error          <= 1'b0;
            req_rdata          <= '0;
            busy               <= 1'b0;
        end else begin
            state              <= state_d;
            rr_ptr             <= rr_ptr_d;
            id_q               <= id_d;
            write_q            <= write_d;
            cnt_q              <= cnt_d;
            register_operation <= op_d;
            register_number    <= number_d;
            register_write     <= wdata_d;
            req_done           <= done_d;
            req_error          <= error_d;
            req_rdata          <= rdata_d;
            busy               <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_axi_register_port_arbiter.sv
// Directed bench for axi_register_port_arbiter: READ_LATENCY=1 instance with a register-file
// slave model, plus a READ_LATENCY=3 instance whose slave only presents data on the third wait cycle.
module tb_axi_register_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Instance with READ_LATENCY = 1
    logic [3:0]   req_valid, req_write, req_done;
    logic [31:0]  req_number;
    logic [127:0] req_wdata;
    logic         req_error, busy;
    logic [31:0]  req_rdata, register_write, register_read;
    logic [1:0]   register_operation;
    logic [7:0]   register_number;

    // Instance with READ_LATENCY = 3
    logic [3:0]   valid3, write3, done3;
    logic [31:0]  number3;
    logic [127:0] wdata3;
    logic         error3, busy3;
    logic [31:0]  rdata3, reg_write3, reg_read3;
    logic [1:0]   op3;
    logic [7:0]   reg_number3;

    int checks = 0;
    int errors = 0;

    axi_register_port_arbiter #(
        .NUMBER_OF_REQUESTERS(4), .C_S_AXI_DATA_WIDTH(32),
        .NUMBER_OF_REGISTERS(6), .READ_LATENCY(1)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_number(req_number),
        .req_wdata(req_wdata), .req_done(req_done), .req_error(req_error),
        .req_rdata(req_rdata), .busy(busy), .register_operation(register_operation),
        .register_number(register_number), .register_write(register_write),
        .register_read(register_read)
    );

    axi_register_port_arbiter #(
        .NUMBER_OF_REQUESTERS(4), .C_S_AXI_DATA_WIDTH(32),
        .NUMBER_OF_REGISTERS(6), .READ_LATENCY(3)
    ) dut3 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .req_valid(valid3), .req_write(write3), .req_number(number3),
        .req_wdata(wdata3), .req_done(done3), .req_error(error3),
        .req_rdata(rdata3), .busy(busy3), .register_operation(op3),
        .register_number(reg_number3), .register_write(reg_write3),
        .register_read(reg_read3)
    );

    // Register-file slave: read data valid only in the cycle after the read op
    logic [31:0] mem [0:255];
    logic        rd_valid;
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;
    always @(posedge clk) begin
        rd_valid <= rst_n && (register_operation == 2'd1);
        if (register_operation == 2'd2) mem[register_number] <= register_write;
        if (pre_en) mem[pre_addr] <= pre_data;
    end
    assign register_read = rd_valid ? mem[register_number] : 32'h0BAD0BAD;

    // Slow slave: data only on the third cycle after the read op
    logic [2:0] cnt3;
    always @(posedge clk) begin
        if (!rst_n)                       cnt3 <= 3'd0;
        else if (op3 == 2'd1)             cnt3 <= 3'd1;
        else if (cnt3 != 0 && cnt3 != 7)  cnt3 <= cnt3 + 3'd1;
    end
    assign reg_read3 = (cnt3 == 3'd3) ? 32'hCAFEF00D : 32'h0BAD0BAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (register_operation !== 2'd0) begin errors++; $display("FAIL reset_op got %0d exp 0", register_operation); end
        checks++; if (register_number !== 8'd0) begin errors++; $display("FAIL reset_number got %0d exp 0", register_number); end
        checks++; if (register_write !== 32'd0) begin errors++; $display("FAIL reset_write got %h exp 0", register_write); end
        checks++; if (req_done !== 4'd0 || req_error !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b exp 0000/0", req_done, req_error); end
        checks++; if (req_rdata !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_rdata_busy got %h/%b exp 0/0", req_rdata, busy); end
        checks++; if (op3 !== 2'd0 || busy3 !== 1'b0 || done3 !== 4'd0) begin errors++; $display("FAIL reset_dut3 got op %0d busy %b done %b exp 0", op3, busy3, done3); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        preload(8'd3, 32'hDEADBEEF);
        req_valid = 4'b0010; req_write = 4'b0000; req_number = 32'h0000_0300;
        tick();
        checks++; if (register_operation !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL single_read_issue got op %0d busy %b exp 1/1", register_operation, busy); end
        checks++; if (register_number !== 8'd3) begin errors++; $display("FAIL single_read_number got %0d exp 3", register_number); end
        req_valid = 4'b0000;
        tick();
        checks++; if (register_operation !== 2'd0 || req_done !== 4'd0) begin errors++; $display("FAIL single_read_wait got op %0d done %b exp 0/0000", register_operation, req_done); end
        tick();
        checks++; if (register_operation !== 2'd3 || req_done !== 4'b0010 || req_error !== 1'b0) begin errors++; $display("FAIL single_read_complete got op %0d done %b err %b exp 3/0010/0", register_operation, req_done, req_error); end
        checks++; if (req_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_read_rdata got %h exp deadbeef", req_rdata); end
        tick();
        checks++; if (req_done !== 4'd0 || busy !== 1'b0 || register_operation !== 2'd0) begin errors++; $display("FAIL single_read_idle got done %b busy %b op %0d exp 0", req_done, busy, register_operation); end
    endtask

    task automatic test_write_read();
        logic [1:0] exp_ops [0:6];
        exp_ops = '{2'd2, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3};
        req_valid = 4'b0001; req_write = 4'b0001; req_number = 32'h0000_0005;
        req_wdata = 128'h0;
        req_wdata[31:0] = 32'h12345678;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (register_operation !== exp_ops[i]) begin errors++; $display("FAIL write_read_op[%0d] got %0d exp %0d", i, register_operation, exp_ops[i]); end
            if (i == 0) begin
                checks++; if (register_write !== 32'h12345678 || register_number !== 8'd5) begin errors++; $display("FAIL write_issue_fields got %h/%0d exp 12345678/5", register_write, register_number); end
            end
            if (i == 2) begin
                checks++; if (req_done !== 4'b0001 || req_rdata !== 32'd0) begin errors++; $display("FAIL write_complete got done %b rdata %h exp 0001/0", req_done, req_rdata); end
                req_write = 4'b0000;
            end
        end
        checks++; if (req_done !== 4'b0001 || req_rdata !== 32'h12345678) begin errors++; $display("FAIL readback got done %b rdata %h exp 0001/12345678", req_done, req_rdata); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_contention();
        logic [3:0]  exp_done;
        logic [31:0] exp_data;
        int          g;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) preload(8'(i), 32'h11111111 * 32'(i + 1));
        req_write = 4'b0000; req_number = 32'h0302_0100; req_valid = 4'b1111;
        for (int t = 1; t <= 19; t++) begin
            tick();
            g = (t - 3) / 4;
            exp_done = (t >= 3 && (t - 3) % 4 == 0) ? (4'd1 << (g % 4)) : 4'd0;
            exp_data = 32'h11111111 * 32'((g % 4) + 1);
            checks++; if (req_done !== exp_done) begin errors++; $display("FAIL contention_done t=%0d got %b exp %b", t, req_done, exp_done); end
            if (exp_done != 4'd0) begin
                checks++; if (req_rdata !== exp_data) begin errors++; $display("FAIL contention_rdata t=%0d got %h exp %h", t, req_rdata, exp_data); end
            end
        end
        req_valid = 4'b0000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL contention_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] prev_number;
        prev_number = register_number;
        req_valid = 4'b0100; req_write = 4'b0000; req_number = 32'h0006_0000;
        tick();
        checks++; if (req_done !== 4'b0100 || req_error !== 1'b1) begin errors++; $display("FAIL oor_done got done %b err %b exp 0100/1", req_done, req_error); end
        checks++; if (register_operation !== 2'd0 || req_rdata !== 32'd0 || busy !== 1'b1) begin errors++; $display("FAIL oor_port got op %0d rdata %h busy %b exp 0/0/1", register_operation, req_rdata, busy); end
        checks++; if (register_number !== prev_number) begin errors++; $display("FAIL oor_number got %0d exp %0d", register_number, prev_number); end
        req_valid = 4'b0000;
        tick();
        checks++; if (req_done !== 4'd0 || req_error !== 1'b0 || register_operation !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL oor_after got done %b err %b op %0d busy %b exp 0", req_done, req_error, register_operation, busy); end
    endtask

    task automatic test_reset_mid_op();
        req_valid = 4'b0010; req_write = 4'b0000; req_number = 32'h0000_0200;
        tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (busy !== 1'b1 || register_operation !== 2'd0) begin errors++; $display("FAIL midrst_wait got busy %b op %0d exp 1/0", busy, register_operation); end
        rst_n = 1'b0;
        tick();
        checks++; if (register_operation !== 2'd0 || req_done !== 4'd0 || busy !== 1'b0 || req_rdata !== 32'd0 || register_number !== 8'd0) begin errors++; $display("FAIL midrst_outputs got op %0d done %b busy %b rdata %h num %0d exp 0", register_operation, req_done, busy, req_rdata, register_number); end
        rst_n = 1'b1;
        tick();
        checks++; if (req_done !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_done got done %b busy %b exp 0/0", req_done, busy); end
        req_valid = 4'b1001; req_number = 32'h0400_0001;
        tick();
        checks++; if (register_operation !== 2'd1 || register_number !== 8'd1) begin errors++; $display("FAIL midrst_grant0 got op %0d num %0d exp 1/1", register_operation, register_number); end
        req_valid = 4'b1000;
        tick(); tick();
        checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL midrst_done0 got %b exp 0001", req_done); end
        tick(); tick();
        checks++; if (register_operation !== 2'd1 || register_number !== 8'd4) begin errors++; $display("FAIL midrst_grant3 got op %0d num %0d exp 1/4", register_operation, register_number); end
        tick(); tick();
        checks++; if (req_done !== 4'b1000) begin errors++; $display("FAIL midrst_done3 got %b exp 1000", req_done); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_read_latency3();
        logic [1:0] exp_op [1:6];
        exp_op = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        valid3 = 4'b0001; write3 = 4'b0000; number3 = 32'h0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 1) valid3 = 4'b0000;
            checks++; if (op3 !== exp_op[t]) begin errors++; $display("FAIL lat3_op t=%0d got %0d exp %0d", t, op3, exp_op[t]); end
            checks++; if (done3 !== ((t == 5) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL lat3_done t=%0d got %b", t, done3); end
            checks++; if (busy3 !== (t <= 5)) begin errors++; $display("FAIL lat3_busy t=%0d got %b", t, busy3); end
            if (t == 5) begin
                checks++; if (rdata3 !== 32'hCAFEF00D) begin errors++; $display("FAIL lat3_rdata got %h exp cafef00d", rdata3); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_number = '0; req_wdata = '0;
        valid3 = '0; write3 = '0; number3 = '0; wdata3 = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_reset_mid_op();
        test_read_latency3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_register_port_arbiter.md
# axi_register_port_arbiter

Round-robin arbiter that shares the user-side register port of `axi_slave_impl` among several internal requesters, such as the image-processing cores and the DMA control. It grants one requester at a time and sequences the port's operation codes: 1 = read, 2 = write, 3 = complete. For a read it captures `register_read` and returns it to the granted requester with a one-cycle done pulse. Register numbers that are out of range are rejected without touching the port.

## Interface
- NUMBER_OF_REQUESTERS, 4, number of clients N (2..8)
- C_S_AXI_DATA_WIDTH, 32, register data width DW
- NUMBER_OF_REGISTERS, 6, valid register numbers are 0..NUMBER_OF_REGISTERS-1
- READ_LATENCY, 1, cycles after the read op before `register_read` is valid (>=1)
- S_AXI_ACLK  in  1  single clock
- S_AXI_ARESETN  in  1  synchronous, active-low reset
- req_valid  in  N  per-requester request
- req_write  in  N  per-requester direction: 1 = write, 0 = read
- req_number  in  8*N  register number, requester i at [8i+7:8i]
- req_wdata  in  DW*N  write data, requester i at [DW*i+DW-1:DW*i]
- req_done  out  N  one-cycle completion pulse, one-hot
- req_error  out  1  qualifies `req_done`: register number out of range
- req_rdata  out  DW  read data, valid while `req_done` is high
- busy  out  1  a transaction is in flight (state != IDLE)
- register_operation  out  2  to slave: 0 idle, 1 read, 2 write, 3 complete
- register_number  out  8  to slave
- register_write  out  DW  to slave
- register_read  in  DW  from slave

## Operation
- FSM states: IDLE, ISSUE, WAIT, COMPLETE, ERROR.
- **IDLE:**
  - If any `req_valid` is high, pick the first set bit searching from `rr_ptr` upward, modulo N.
  - Latch that requester's id, `write`, `number` and `wdata`.
  - Set `rr_ptr` = id+1 mod N.
  - If number >= NUMBER_OF_REGISTERS, go to ERROR; otherwise go to ISSUE.
- **ISSUE** (1 cycle): `register_operation` = 2 if write, else 1. `register_number` and `register_write` carry the latched values. Go to WAIT.
- **WAIT** (READ_LATENCY cycles, counted by a down-counter): `register_operation` = 0; number and data are held. On the last WAIT cycle, capture `register_read` for a read. Go to COMPLETE.
- **COMPLETE** (1 cycle):
  - `register_operation` = 3.
  - `req_done[id]` = 1, `req_error` = 0.
  - `req_rdata` = the captured value for a read, 0 for a write.
  - Go to IDLE.
- **ERROR** (1 cycle): `req_done[id]` = 1, `req_error` = 1, `req_rdata` = 0. `register_operation` stays 0. Go to IDLE.
- Request fields are latched at grant. A requester may drop `req_valid` after grant; the transaction still completes and `req_done` still pulses.
- A requester must deassert `req_valid` in the cycle after its `req_done`, otherwise a new transaction is issued.
- The `rr_ptr` update gives fairness: with all requesters continuously valid, grant order is 0,1,...,N-1,0.
- Transactions are never overlapped or pipelined.
- **Reset:**
  - All outputs are 0: `register_operation`, `register_number`, `register_write`, `req_done`, `req_error`, `req_rdata`, `busy`.
  - Internal state: FSM = IDLE, `rr_ptr` = 0.
- Reset asserted mid-transaction aborts it: no done pulse is emitted and `register_operation` is 0 from the next edge.

## Timing
- All outputs are registered.
- Request first seen high in IDLE at cycle T:
  - `register_operation` = 1/2 during cycle T+1.
  - `register_operation` = 3 and `req_done` during cycle T+2+READ_LATENCY.
  - FSM back in IDLE at T+3+READ_LATENCY, which can grant a new request in that same cycle.
- Back-to-back throughput with READ_LATENCY=1: one transaction per 4 cycles.
- Error path: `req_done` with `req_error` during cycle T+1; back in IDLE at T+2.
- `busy` is high from T+1 through the COMPLETE or ERROR cycle inclusive.
- `register_number` and `register_write` are stable from ISSUE through COMPLETE.

## Test plan
- **Single read:** reset; slave reg3 = 0xDEADBEEF; requester 1 reads number 3.
  - Expect op = 1 at T+1 and op = 3 at T+3.
  - Expect `req_done` = 4'b0010 and `req_rdata` = 0xDEADBEEF at T+3.
- **Write then read back:** requester 0 writes 0x12345678 to reg 5, then reads reg 5.
  - Expect op sequence 2,0,3,0,1,0,3.
  - Expect the second `req_rdata` = 0x12345678.
- **Contention:** all four requesters valid continuously, each reading a distinct register.
  - Expect grants 0,1,2,3,0 with `req_done` spaced 4 cycles apart.
  - Expect `rr_ptr` wrap from 3 to 0.
- **Out of range:** requester 2 reads number 6 (NUMBER_OF_REGISTERS = 6).
  - Expect `req_done` = 4'b0100 and `req_error` = 1 at T+1.
  - Expect `register_operation` to stay 0 throughout.
- **Reset mid-operation:** assert `S_AXI_ARESETN` = 0 during WAIT of a read.
  - Expect all outputs 0 the next cycle and no `req_done`.
  - After release, a request from requester 3 with requester 0 also valid grants requester 0 first (`rr_ptr` = 0).
- **READ_LATENCY=3 build:** a read from requester 0.
  - Expect three WAIT cycles with op = 0.
  - Expect data sampled on the third WAIT cycle and `req_done` at T+5.
